// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-channel registered multiplexer and its
// round-robin arbiter.
package mux_arb_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo N, and proposes the pointer for the cycle after a granted transfer.
module rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic [PW-1:0] ptr_nxt
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic           hit;
   int             pos;
   int             idx;

   // NOTE: every combinational output gets a default before any conditional
   // assignment, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      mask    = '0;
      hit     = 1'b0;
      pos     = 0;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      ptr_nxt = ptr;

      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      // Low half holds requests at or above ptr, high half the full set, so the
      // lowest set bit is the first requester in wrapped order.
      dbl = {req, req & mask};
      for (int i = 2*N-1; i >= 0; i--) begin
         if (dbl[i]) begin
            hit = 1'b1;
            pos = i;
         end
      end
      idx = (pos >= N) ? pos - N : pos;

      if (hit) begin
         gnt[idx] = 1'b1;
         gnt_idx  = PW'(idx);
      end
      if (advance) begin
         ptr_nxt = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
      end
   end

endmodule

// File: rtl/mux_arb_nch.sv
// Registered N-channel multiplexer with valid/ready on every port, selecting a
// source either by explicit index or by round-robin arbitration.
module mux_arb_nch
   import mux_arb_pkg::*;
#(
   parameter  int WIDTH    = 16,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
   logic [SEL_W-1:0]    ptr_q,       ptr_d;

   logic [CHANNELS-1:0] sel_gnt, rr_gnt, grant;
   logic [SEL_W-1:0]    rr_idx;
   logic [WIDTH-1:0]    mux_data;
   logic                can_accept, xfer_in, rr_advance;

   rr_arbiter #(.N(CHANNELS)) u_rr (
      .req     (in_valid),
      .ptr     (ptr_q),
      .advance (rr_advance),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .ptr_nxt (ptr_d)
   );

   always_comb begin
      sel_gnt     = '0;
      mux_data    = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;

      // An out-of-range sel matches no channel and therefore grants nothing.
      for (int i = 0; i < CHANNELS; i++) begin
         sel_gnt[i] = in_valid[i] && (sel == SEL_W'(i));
      end
      grant = (mode == MODE_RR) ? rr_gnt : sel_gnt;

      // Single-entry pipe: take a new word when empty or when the held word leaves.
      can_accept = !out_valid_q || out_ready;
      in_ready   = rst_n ? (grant & {CHANNELS{can_accept}}) : '0;
      xfer_in    = |(in_valid & in_ready);
      rr_advance = xfer_in && (mode == MODE_RR);

      for (int i = 0; i < CHANNELS; i++) begin
         if (grant[i]) mux_data = in_data[i*WIDTH +: WIDTH];
      end

      if (xfer_in) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data;
         out_chan_d  = (mode == MODE_RR) ? rr_idx : sel;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples the
   // pre-edge values of the others, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_nch.sv
// Directed bench for mux_arb_nch: stimulus pushes expected words into a
// scoreboard queue, a monitor pops and compares each word the DUT hands off.
module tb_mux_arb_nch;

   localparam int W = 16;
   localparam int N = 4;

   typedef struct {
      logic [1:0]   chan;
      logic [W-1:0] data;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic           mode;
   logic [1:0]     sel;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic [1:0]     out_chan;
   logic           out_valid;
   logic           out_ready;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   mux_arb_nch #(.WIDTH(W), .CHANNELS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   task automatic expect_word(input logic [1:0] c, input logic [W-1:0] d);
      exp_t e;
      e.chan = c;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      in_valid  = '0;
      out_ready = 1'b1;
      step(2);
   endtask

   // Monitor: every handed-off word must be the next one the stimulus predicted.
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready_onehot", ($countones(in_ready) <= 1), 1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_chan", out_chan, e.chan);
               check("sb_data", out_data, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;

      // Reset state, with requests present to prove in_ready is masked.
      #12;
      in_valid = 4'hF;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_chan",  out_chan,  0);
      check("rst_in_ready",  in_ready,  0);
      in_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset mid-stream drops the held word immediately.
      set_data(16'h1111, 16'h0, 16'h0, 16'h0);
      in_valid = 4'b0001;
      step(1);
      check("t1_loaded_valid", out_valid, 1);
      check("t1_loaded_data",  out_data,  16'h1111);
      in_valid = '0;
      #2;
      rst_n    = 1'b0;
      in_valid = 4'hF;
      #1;
      check("t1_rst_out_valid", out_valid, 0);
      check("t1_rst_out_data",  out_data,  0);
      check("t1_rst_out_chan",  out_chan,  0);
      check("t1_rst_in_ready",  in_ready,  0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = '0;
      step(1);

      // Explicit select of channel 2.
      mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
      set_data(16'hA000, 16'hA001, 16'hBEEF, 16'hA003);
      in_valid = 4'hF;
      #1;
      check("t2_in_ready", in_ready, 4'b0100);
      expect_word(2'd2, 16'hBEEF);
      step(1);
      check("t2_out_data",  out_data,  16'hBEEF);
      check("t2_out_chan",  out_chan,  2);
      check("t2_out_valid", out_valid, 1);
      drain();

      // Round-robin, all channels valid, full throughput.
      mode = 1'b1;
      set_data(16'hC000, 16'hC001, 16'hC002, 16'hC003);
      begin
         logic [1:0] seq [5];
         seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
         for (int k = 0; k < 5; k++) expect_word(seq[k], 16'hC000 + 16'(seq[k]));
         in_valid = 4'hF;
         for (int k = 0; k < 5; k++) begin
            step(1);
            check("t3_out_valid", out_valid, 1);
            check("t3_out_chan",  out_chan,  seq[k]);
         end
      end
      drain();

      // Sparse requests: move ptr to 2, then ch1/ch3 alternate with wrap.
      set_data(16'hD000, 16'hD001, 16'hD002, 16'hD003);
      in_valid = 4'b0010;
      expect_word(2'd1, 16'hD001);
      step(1);
      in_valid = 4'b1010;
      #1;
      check("t4_in_ready_ptr2", in_ready, 4'b1000);
      expect_word(2'd3, 16'hD003);
      expect_word(2'd1, 16'hD001);
      expect_word(2'd3, 16'hD003);
      step(1);
      check("t4_in_ready_ptr0", in_ready, 4'b0010);
      step(2);
      check("t4_last_chan", out_chan, 3);
      drain();

      // Back-pressure: held word stable, no input accepted, then resume.
      out_ready = 1'b0;
      set_data(16'hE000, 16'hE001, 16'hE002, 16'hE003);
      in_valid = 4'b0001;
      expect_word(2'd0, 16'hE000);
      step(1);
      in_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t5_stall_data",     out_data,  16'hE000);
         check("t5_stall_chan",     out_chan,  0);
         check("t5_stall_in_ready", in_ready,  0);
         step(1);
      end
      out_ready = 1'b1;
      #1;
      check("t5_release_in_ready", in_ready, 4'b0010);
      expect_word(2'd1, 16'hE001);
      step(1);
      check("t5_next_data", out_data, 16'hE001);
      check("t5_next_chan", out_chan, 1);
      drain();

      // Mode switch while stalled; RR pointer must survive explicit mode.
      out_ready = 1'b0; mode = 1'b1;
      set_data(16'hF000, 16'hF001, 16'hF002, 16'hF003);
      in_valid = 4'b0100;
      expect_word(2'd2, 16'hF002);
      step(1);
      mode = 1'b0; sel = 2'd1;
      set_data(16'hF100, 16'hF101, 16'hF102, 16'hF103);
      in_valid = 4'hF;
      step(2);
      check("t6_held_data", out_data, 16'hF002);
      check("t6_held_chan", out_chan, 2);
      out_ready = 1'b1;
      expect_word(2'd1, 16'hF101);
      step(1);
      check("t6_sel_chan", out_chan, 1);
      drain();
      mode = 1'b1;
      set_data(16'hF200, 16'hF201, 16'hF202, 16'hF203);
      in_valid = 4'hF;
      #1;
      check("t6_rr_ptr_kept", in_ready, 4'b1000);
      expect_word(2'd3, 16'hF203);
      step(1);
      drain();

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1);
      check("sb_all_delivered", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
